sic1_cpu: RTL and testbench
===========================

// Module: sic1_cpu
// PURPOSE
//   SUBLEQ execution core for the SIC-1 design; drives the sic1_memory address/data bus directly.
//   Each instruction is three bytes at pc: A, B, C.
//   Semantics: mem[A] <= mem[A] - mem[B]; if the 8-bit result is <= 0 (signed) pc <= C, else pc <= pc+3.
//   Reaching address ADDR_HALT halts the core. I/O is memory-mapped by sic1_memory (253 = IN, 254 = OUT).
// PARAMETERS
//   RESET_PC   8'd0    pc loaded on reset
//   ADDR_HALT  8'd255  next-pc value that stops execution
// PORTS
//   clk        in   1  clock, all state updates on rising edge
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  run enable; low = stall in current state
//   mem_addr   out  8  memory address (combinational from state/regs)
//   mem_rdata  in   8  memory read data, combinational from mem_addr
//   mem_wr_en  out  1  memory write strobe, high only in EXEC
//   mem_wdata  out  8  write data = va - vb (mod 256)
//   pc         out  8  current program counter
//   halted     out  1  high once ADDR_HALT reached
// BEHAVIOUR
//   Reset (async, rst_n=0): state=FETCH_A, pc=RESET_PC, a=b=c=va=vb=0.
//     Outputs during reset: mem_addr=RESET_PC, mem_wr_en=0, mem_wdata=0, halted=0.
//   FSM: 7 states, 6 clocks per instruction when en=1.
//     Each non-halt state drives mem_addr and captures mem_rdata on the clock edge:
//     FETCH_A : addr=pc      ; a  <= rdata ; -> FETCH_B
//     FETCH_B : addr=pc+1    ; b  <= rdata ; -> FETCH_C
//     FETCH_C : addr=pc+2    ; c  <= rdata ; -> LOAD_A
//     LOAD_A  : addr=a       ; va <= rdata ; -> LOAD_B
//     LOAD_B  : addr=b       ; vb <= rdata ; -> EXEC
//     EXEC    : addr=a, mem_wr_en=1, mem_wdata=va-vb.
//               Branch taken when r==0 or r[7]==1, with r=va-vb.
//               pc <= taken ? c : pc+3 (mod 256).
//               next pc == ADDR_HALT -> HALTED, else -> FETCH_A.
//     HALTED  : addr=pc, wr_en=0, halted=1; absorbing until rst_n low.
//   Arithmetic: 8-bit two's complement wraparound; overflow ignored.
//     The branch decision uses the sign of the truncated 8-bit result only.
//   pc+1, pc+2 and pc+3 wrap modulo 256; operand fetch across 0xFF->0x00 is legal.
//   en=0: state and all registers hold; mem_wr_en forced 0; mem_addr still driven.
//     en may drop in any state, including EXEC; that write is deferred until en returns.
//   Exactly one write per instruction, issued in EXEC.
//     A=253/255 write is dropped by memory; A=254 emits OUT strobe.
//   Reads of 253 return ui_in; reads of 254/255 return 0. No special casing here.
//   Reset mid-instruction: immediate return to FETCH_A at RESET_PC; no write issued.
//     A partially fetched instruction is discarded.
// TESTING
//   1 Reset: hold rst_n=0 mid-EXEC -> mem_wr_en drops async; mem_addr=0x00, pc=0x00, halted=0.
//   2 Positive path: instr@0 = (0x10,0x11,0x20), mem[0x10]=5, mem[0x11]=2
//       -> 6th cycle: wr_en=1, addr=0x10, wdata=0x03; pc=0x03.
//   3 Branch: mem[0x10]=2, mem[0x11]=5 -> wdata=0xFD, pc=0x20.
//     Equal operands -> wdata=0x00, pc=0x20.
//     Signed wrap: 0x80-0x01 -> wdata=0x7F, not taken, pc=0x03.
//   4 Output: instr (254,0x11,0x00), mem[0x11]=0xD6 -> wdata=0x2A at addr 254.
//     uo_out=0x2A, out_strobe=1, pc=0x03.
//   5 Halt: instr (0x10,0x10,0xFF) -> write 0x00, halted=1 next cycle.
//     No further wr_en for 20 cycles; pc stays 0xFF.
//     Also pc=0xFC, result>0 -> pc+3=0xFF -> halted.
//   6 Stall: toggle en=0 for 3 cycles in each state -> identical memory trace to en=1 run.
//     Total cycles +3 per stall; no write while en=0.

Source files
------------

// File: rtl/sic1_cpu.sv
// SUBLEQ execution core: fetches (A, B, C) at pc, writes mem[A] - mem[B] back to A and
// branches to C when the 8-bit signed result is <= 0. Six clocks per instruction while en is high.
module sic1_cpu #(
  parameter logic [7:0] RESET_PC  = 8'd0,
  parameter logic [7:0] ADDR_HALT = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  output logic [7:0] pc,
  output logic       halted
);

  typedef enum logic [2:0] {
    StFetchA,
    StFetchB,
    StFetchC,
    StLoadA,
    StLoadB,
    StExec,
    StHalted
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] c_q, c_d;
  logic [7:0] va_q, va_d;
  logic [7:0] vb_q, vb_d;

  logic [7:0] result;
  logic       taken;
  logic [7:0] pc_p1, pc_p2, pc_p3;
  logic [7:0] pc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetchA;
      pc_q    <= RESET_PC;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      c_q     <= 8'd0;
      va_q    <= 8'd0;
      vb_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
    end
  end

  // Branch on the sign of the truncated result only; signed overflow is ignored.
  assign result  = va_q - vb_q;
  assign taken   = (result == 8'd0) || result[7];
  assign pc_p1   = pc_q + 8'd1;
  assign pc_p2   = pc_q + 8'd2;
  assign pc_p3   = pc_q + 8'd3;
  assign pc_next = taken ? c_q : pc_p3;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    va_d      = va_q;
    vb_d      = vb_q;
    mem_addr  = pc_q;
    mem_wr_en = 1'b0;

    unique case (state_q)
      StFetchA: begin
        mem_addr = pc_q;
        if (en) begin
          a_d     = mem_rdata;
          state_d = StFetchB;
        end
      end
      StFetchB: begin
        mem_addr = pc_p1;
        if (en) begin
          b_d     = mem_rdata;
          state_d = StFetchC;
        end
      end
      StFetchC: begin
        mem_addr = pc_p2;
        if (en) begin
          c_d     = mem_rdata;
          state_d = StLoadA;
        end
      end
      StLoadA: begin
        mem_addr = a_q;
        if (en) begin
          va_d    = mem_rdata;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        mem_addr = b_q;
        if (en) begin
          vb_d    = mem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        // A stalled EXEC holds its write until en returns, so each instruction writes once.
        mem_addr  = a_q;
        mem_wr_en = en;
        if (en) begin
          pc_d    = pc_next;
          state_d = (pc_next == ADDR_HALT) ? StHalted : StFetchA;
        end
      end
      StHalted: begin
        mem_addr = pc_q;
      end
      default: begin
        state_d = StFetchA;
      end
    endcase
  end

  assign mem_wdata = result;
  assign pc        = pc_q;
  assign halted    = (state_q == StHalted);

endmodule

// File: tb/tb_sic1_cpu.sv
// Directed bench for sic1_cpu with a small behavioural sic1_memory model (253 = IN, 254 = OUT).
module tb_sic1_cpu;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] pc;
  logic       halted;

  sic1_cpu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .pc        (pc),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model; the bench loads it through ld_en/clr so the array has a single writer.
  logic [7:0] mem [256];
  logic [7:0] ui_in;
  logic [7:0] uo_out = 8'h00;
  logic       out_strobe = 1'b0;
  logic       clr, ld_en;
  logic [7:0] ld_addr, ld_data;
  logic [7:0] tr_addr [128];
  logic [7:0] tr_data [128];
  int         tr_n = 0;

  assign mem_rdata = (mem_addr == 8'd253) ? ui_in :
                     (mem_addr >= 8'd254) ? 8'h00 : mem[mem_addr];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_wr_en && mem_addr < 8'd253) begin
      mem[mem_addr] <= mem_wdata;
    end
    out_strobe <= mem_wr_en && (mem_addr == 8'd254);
    if (mem_wr_en && mem_addr == 8'd254) uo_out <= mem_wdata;
    if (mem_wr_en && tr_n < 128) begin
      tr_addr[tr_n] <= mem_addr;
      tr_data[tr_n] <= mem_wdata;
      tr_n          <= tr_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Load helpers are called right after a falling edge.
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic load_instr(input logic [7:0] at, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
    poke(at, a);
    poke(at + 8'd1, b);
    poke(at + 8'd2, c);
  endtask

  task automatic prep;
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    clr   = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
  endtask

  task automatic run_basic(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] exp_wd, input logic [7:0] exp_pc);
    prep();
    load_instr(8'h00, 8'h10, 8'h11, 8'h20);
    poke(8'h10, va);
    poke(8'h11, vb);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check({tag, "_prewr"}, 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    check({tag, "_wr"}, 32'(mem_wr_en), 32'd1);
    check({tag, "_addr"}, 32'(mem_addr), 32'h10);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'(exp_wd));
    @(negedge clk);
    check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    check({tag, "_mem"}, 32'(mem[8'h10]), 32'(exp_wd));
    check({tag, "_fetch"}, 32'(mem_addr), 32'(exp_pc));
  endtask

  // Countdown loop: ten instructions, halting through the instruction at 0x09.
  task automatic run_loop(input bit stall, output int cycles, output int stalls,
                          output int bad_wr, output int base);
    int cyc;
    prep();
    load_instr(8'h00, 8'h30, 8'h31, 8'h09);
    load_instr(8'h03, 8'h32, 8'h32, 8'h00);
    load_instr(8'h09, 8'h33, 8'h33, 8'hFF);
    poke(8'h30, 8'h05);
    poke(8'h31, 8'h01);
    poke(8'h32, 8'h07);
    poke(8'h33, 8'h09);
    base   = tr_n;
    stalls = 0;
    bad_wr = 0;
    cyc    = 0;
    rst_n  = 1'b1;
    while (!halted && cyc < 500) begin
      en = stall ? ((cyc % 10) < 7) : 1'b1;
      if (!en) stalls++;
      #1;
      if (!en && mem_wr_en) bad_wr++;
      @(negedge clk);
      cyc++;
    end
    en     = 1'b1;
    cycles = cyc;
  endtask

  logic [7:0] exp_ta [10] = '{8'h30, 8'h32, 8'h30, 8'h32, 8'h30, 8'h32, 8'h30, 8'h32,
                              8'h30, 8'h33};
  logic [7:0] exp_td [10] = '{8'h04, 8'h00, 8'h03, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00,
                              8'h00, 8'h00};

  initial begin
    int cycles, stalls, bad_wr, base, wcount;
    rst_n   = 1'b0;
    en      = 1'b1;
    ui_in   = 8'h00;
    clr     = 1'b0;
    ld_en   = 1'b0;
    ld_addr = 8'h00;
    ld_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(mem_addr), 32'h00);
    check("rst_wr", 32'(mem_wr_en), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'h00);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_halted", 32'(halted), 32'd0);

    run_basic("pos", 8'h05, 8'h02, 8'h03, 8'h03);
    run_basic("neg", 8'h02, 8'h05, 8'hFD, 8'h20);
    run_basic("eq", 8'h07, 8'h07, 8'h00, 8'h20);
    run_basic("wrap", 8'h80, 8'h01, 8'h7F, 8'h03);

    // Async reset while the second instruction is in EXEC.
    prep();
    load_instr(8'h00, 8'h10, 8'h11, 8'h20);
    load_instr(8'h03, 8'h12, 8'h13, 8'h40);
    poke(8'h10, 8'h05);
    poke(8'h11, 8'h02);
    poke(8'h12, 8'h09);
    poke(8'h13, 8'h01);
    rst_n = 1'b1;
    repeat (11) @(negedge clk);
    check("mid_wr", 32'(mem_wr_en), 32'd1);
    check("mid_addr", 32'(mem_addr), 32'h12);
    check("mid_pc", 32'(pc), 32'h03);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wr", 32'(mem_wr_en), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'h00);
    check("arst_pc", 32'(pc), 32'h00);
    check("arst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    check("arst_nowrite", 32'(mem[8'h12]), 32'h09);

    // OUT port: 0 - 0xD6 = 0x2A, positive so fall through.
    prep();
    load_instr(8'h00, 8'hFE, 8'h11, 8'h00);
    poke(8'h11, 8'hD6);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("out_addr", 32'(mem_addr), 32'hFE);
    check("out_wdata", 32'(mem_wdata), 32'h2A);
    @(negedge clk);
    check("out_uo", 32'(uo_out), 32'h2A);
    check("out_strobe", 32'(out_strobe), 32'd1);
    check("out_pc", 32'(pc), 32'h03);

    // Halt via taken branch to 0xFF.
    prep();
    load_instr(8'h00, 8'h10, 8'h10, 8'hFF);
    poke(8'h10, 8'h04);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("halt_wdata", 32'(mem_wdata), 32'h00);
    check("halt_pre", 32'(halted), 32'd0);
    @(negedge clk);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'hFF);
    check("halt_mem", 32'(mem[8'h10]), 32'h00);
    wcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_wr_en) wcount++;
    end
    check("halt_nowr", 32'(wcount), 32'd0);
    check("halt_pc20", 32'(pc), 32'hFF);

    // Halt via fall-through from 0xFC; B comes from the IN port, C reads as 0.
    prep();
    ui_in = 8'h21;
    load_instr(8'h00, 8'h10, 8'h11, 8'hFC);
    poke(8'hFC, 8'h20);
    poke(8'h10, 8'h01);
    poke(8'h11, 8'h01);
    poke(8'h20, 8'h05);
    poke(8'h21, 8'h02);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("fc_pc", 32'(pc), 32'hFC);
    repeat (5) @(negedge clk);
    check("fc_addr", 32'(mem_addr), 32'h20);
    check("fc_wdata", 32'(mem_wdata), 32'h03);
    @(negedge clk);
    check("fc_halted", 32'(halted), 32'd1);
    check("fc_pc_ff", 32'(pc), 32'hFF);
    ui_in = 8'h00;

    // Same program with and without stalls must give the same write trace.
    run_loop(1'b0, cycles, stalls, bad_wr, base);
    check("run_cycles", 32'(cycles), 32'd60);
    check("run_nwr", 32'(tr_n - base), 32'd10);
    for (int i = 0; i < 10; i++)
      check("run_trace", {16'h0, tr_addr[base+i], tr_data[base+i]},
            {16'h0, exp_ta[i], exp_td[i]});

    run_loop(1'b1, cycles, stalls, bad_wr, base);
    check("stall_cycles", 32'(cycles), 32'd84);
    check("stall_count", 32'(stalls), 32'd24);
    check("stall_badwr", 32'(bad_wr), 32'd0);
    check("stall_nwr", 32'(tr_n - base), 32'd10);
    for (int i = 0; i < 10; i++)
      check("stall_trace", {16'h0, tr_addr[base+i], tr_data[base+i]},
            {16'h0, exp_ta[i], exp_td[i]});
    check("stall_pc", 32'(pc), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
